// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous data-memory port between the LSU
// (port 0) and the debug/program loader (port 1). One transaction at a
// time: handshake in IDLE, one-cycle memory strobe in ISSUE, fixed read
// latency in WAIT, then a one-cycle response pulse to the owner.
//
// Parameters: ADDR_W address width, DATA_W data width (byte mask is
//   DATA_W/8), MEM_LAT memory read latency in cycles (1..4).
// Ports:
//   i_clk, i_rst            clock, async active-high reset
//   i_reqN_*                request valid/addr/wren/wdata/bmask, N=0,1
//   o_reqN_rdy              request accepted this cycle (IDLE only)
//   o_rspN_vld/_rdata       response pulse and load data (0 for stores)
//   o_mem_*                 memory strobe and fields (0 when not strobing)
//   i_mem_rdata             memory read data, MEM_LAT cycles after o_mem_en
//   o_busy, o_grant         transaction in flight / one-hot owner
// Build option: define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration
//   on conflict; otherwise port 0 has fixed priority.

module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic                i_clk,
    input  logic                i_rst,

    input  logic                i_req0_vld,
    output logic                o_req0_rdy,
    input  logic [ADDR_W-1:0]   i_req0_addr,
    input  logic                i_req0_wren,
    input  logic [DATA_W-1:0]   i_req0_wdata,
    input  logic [DATA_W/8-1:0] i_req0_bmask,
    output logic                o_rsp0_vld,
    output logic [DATA_W-1:0]   o_rsp0_rdata,

    input  logic                i_req1_vld,
    output logic                o_req1_rdy,
    input  logic [ADDR_W-1:0]   i_req1_addr,
    input  logic                i_req1_wren,
    input  logic [DATA_W-1:0]   i_req1_wdata,
    input  logic [DATA_W/8-1:0] i_req1_bmask,
    output logic                o_rsp1_vld,
    output logic [DATA_W-1:0]   o_rsp1_rdata,

    output logic                o_mem_en,
    output logic                o_mem_wren,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic [DATA_W/8-1:0] o_mem_bmask,
    input  logic [DATA_W-1:0]   i_mem_rdata,

    output logic                o_busy,
    output logic [1:0]          o_grant
);

    localparam int BM_W = DATA_W / 8;
    localparam logic [1:0] CNT_LOAD = 2'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        cnt;
    logic [1:0]        cnt_nxt;

    logic              owner;
    logic              cap_wren;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;
    logic [BM_W-1:0]   cap_bmask;

    logic              sel;
    logic              hs;
    logic              rsp_fire;

    // sel = 1 picks port 1
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last;

    // on conflict, grant the port that did not win the previous handshake
    always_comb begin
        if (i_req0_vld && i_req1_vld) begin
            sel = ~last;
        end else begin
            sel = ~i_req0_vld;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            last <= 1'b1;
        end else if (hs) begin
            last <= sel;
        end
    end
`else
    always_comb begin
        sel = ~i_req0_vld;
    end
`endif

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        o_req0_rdy = 1'b0;
        o_req1_rdy = 1'b0;
        hs         = 1'b0;
        rsp_fire   = 1'b0;
        unique case (state)
            IDLE: begin
                // reset masks the handshake so every output reads 0
                if ((i_req0_vld || i_req1_vld) && !i_rst) begin
                    o_req0_rdy = ~sel;
                    o_req1_rdy = sel;
                    hs         = 1'b1;
                    state_nxt  = ISSUE;
                end
            end
            ISSUE: begin
                cnt_nxt   = CNT_LOAD;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (cnt == 2'd0) begin
                    rsp_fire  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 2'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
            cnt   <= 2'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            owner     <= 1'b0;
            cap_wren  <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_bmask <= '0;
        end else if (hs) begin
            owner     <= sel;
            cap_wren  <= sel ? i_req1_wren  : i_req0_wren;
            cap_addr  <= sel ? i_req1_addr  : i_req0_addr;
            cap_wdata <= sel ? i_req1_wdata : i_req0_wdata;
            cap_bmask <= sel ? i_req1_bmask : i_req0_bmask;
        end
    end

    assign o_mem_en    = (state == ISSUE);
    assign o_mem_wren  = o_mem_en & cap_wren;
    assign o_mem_addr  = o_mem_en ? cap_addr  : '0;
    assign o_mem_wdata = o_mem_en ? cap_wdata : '0;
    assign o_mem_bmask = o_mem_en ? cap_bmask : '0;

    // both derive only from registers, so they move one cycle after handshake
    assign o_busy  = (state != IDLE);
    assign o_grant = o_busy ? {owner, ~owner} : 2'b00;

    assign o_rsp0_vld   = rsp_fire & ~owner;
    assign o_rsp1_vld   = rsp_fire & owner;
    assign o_rsp0_rdata = (o_rsp0_vld && !cap_wren) ? i_mem_rdata : '0;
    assign o_rsp1_rdata = (o_rsp1_vld && !cap_wren) ? i_mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a
// transaction-level reference model (event times and a byte-masked memory).

module tb_mem_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int BW  = DW / 8;
    localparam int LAT = 3;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          v0, w0, r0, s0;
    logic          v1, w1, r1, s1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1, q0, q1;
    logic [BW-1:0] m0, m1;
    logic          en, mw;
    logic [AW-1:0] ma;
    logic [DW-1:0] md, mrd;
    logic [BW-1:0] mm;
    logic          busy;
    logic [1:0]    grant;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .MEM_LAT(LAT)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req0_vld  (v0),
        .o_req0_rdy  (r0),
        .i_req0_addr (a0),
        .i_req0_wren (w0),
        .i_req0_wdata(d0),
        .i_req0_bmask(m0),
        .o_rsp0_vld  (s0),
        .o_rsp0_rdata(q0),
        .i_req1_vld  (v1),
        .o_req1_rdy  (r1),
        .i_req1_addr (a1),
        .i_req1_wren (w1),
        .i_req1_wdata(d1),
        .i_req1_bmask(m1),
        .o_rsp1_vld  (s1),
        .o_rsp1_rdata(q1),
        .o_mem_en    (en),
        .o_mem_wren  (mw),
        .o_mem_addr  (ma),
        .o_mem_wdata (md),
        .o_mem_bmask (mm),
        .i_mem_rdata (mrd),
        .o_busy      (busy),
        .o_grant     (grant)
    );

    // reference model: one transaction described by its event cycles
    logic [DW-1:0] mem [logic [AW-1:0]];
    int            en_at, rsp_at, free_at;
    logic          last;
    logic          t_own, t_wren;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_wdata, t_rdata;
    logic [BW-1:0] t_bmask;

    logic          e_r0, e_r1, e_en, e_wren, e_s0, e_s1, e_busy;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_d0, e_d1;
    logic [BW-1:0] e_bmask;
    logic [1:0]    e_grant;

    function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
        if (mem.exists(a)) return mem[a];
        return a * 32'h9E37_79B9 + 32'h1234_0001;
    endfunction

    task automatic mem_wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [BW-1:0] m);
        logic [DW-1:0] cur;
        cur = mem_rd(a);
        for (int b = 0; b < BW; b++) begin
            if (m[b]) cur[b*8 +: 8] = d[b*8 +: 8];
        end
        mem[a] = cur;
    endtask

    task automatic model_reset();
        en_at   = -1;
        rsp_at  = -1;
        free_at = cyc;
        last    = 1'b1;
        e_r0    = 1'b0;
        e_r1    = 1'b0;
    endtask

    // computes expected outputs for the current cycle, drives memory data
    task automatic model_cycle();
        logic bz;
        logic win;
        e_r0 = 0; e_r1 = 0; e_en = 0; e_wren = 0;
        e_addr = '0; e_wdata = '0; e_bmask = '0;
        e_s0 = 0; e_s1 = 0; e_d0 = '0; e_d1 = '0;
        bz = (en_at >= 0) && (cyc >= en_at) && (cyc <= rsp_at);
        e_busy  = bz;
        e_grant = bz ? (t_own ? 2'b10 : 2'b01) : 2'b00;
        if (cyc == en_at) begin
            e_en = 1; e_wren = t_wren; e_addr = t_addr;
            e_wdata = t_wdata; e_bmask = t_bmask;
        end
        mrd = $urandom;
        if (cyc == rsp_at) begin
            mrd = t_wren ? '1 : t_rdata;
            if (t_own) begin
                e_s1 = 1; e_d1 = t_wren ? '0 : t_rdata;
            end else begin
                e_s0 = 1; e_d0 = t_wren ? '0 : t_rdata;
            end
        end
        if (cyc >= free_at && (v0 || v1)) begin
            if (v0 && v1) win = (RR && !last) ? 1'b1 : 1'b0;
            else          win = !v0;
            if (win) e_r1 = 1; else e_r0 = 1;
            t_own   = win;
            t_wren  = win ? w1 : w0;
            t_addr  = win ? a1 : a0;
            t_wdata = win ? d1 : d0;
            t_bmask = win ? m1 : m0;
            if (t_wren) mem_wr(t_addr, t_wdata, t_bmask);
            else        t_rdata = mem_rd(t_addr);
            en_at   = cyc + 1;
            rsp_at  = cyc + 1 + LAT;
            free_at = rsp_at + 1;
            last    = win;
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1; v0 = 0; v1 = 0;
        next();
        rst = 0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1; v0 = 1; v1 = 1;
        a0 = 32'h44; a1 = 32'h88; w0 = 0; w1 = 1;
        d0 = '1; d1 = '1; m0 = '1; m1 = '1;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if ((r0 | r1 | s0 | s1 | en | mw | busy | (|q0) | (|q1) | (|ma)
                 | (|md) | (|mm) | (|grant)) !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs cyc=%0d rdy=%b%b rsp=%b%b en=%b busy=%b grant=%b want all 0",
                         cyc, r0, r1, s0, s1, en, busy, grant);
            end
            next();
        end
        rst = 0; v0 = 0; v1 = 0;
        model_reset();
        model_cycle();
        #1;
        checks++;
        if ({busy, grant, en} !== 4'b0) begin
            errors++;
            $display("FAIL reset_idle busy=%b grant=%b en=%b want 0", busy, grant, en);
        end
        next();
    endtask

    task automatic test_load();
        do_reset();
        mem[32'h10] = 32'hDEAD_BEEF;
        v0 = 1; a0 = 32'h10; w0 = 0; d0 = $urandom; m0 = 4'hF; v1 = 0;
        for (int k = 0; k <= LAT + 1; k++) begin
            if (k == 1) v0 = 0;
            model_cycle();
            #1;
            if (k == 0) begin
                checks++;
                if ({r0, r1} !== 2'b10) begin
                    errors++;
                    $display("FAIL load_rdy got %b%b want 10", r0, r1);
                end
            end
            if (k == 1) begin
                checks++;
                if ({en, mw, ma} !== {1'b1, 1'b0, 32'h10}) begin
                    errors++;
                    $display("FAIL load_issue en=%b wren=%b addr=%h want 1 0 00000010", en, mw, ma);
                end
            end
            if (k == LAT + 1) begin
                checks++;
                if ({s0, q0} !== {1'b1, 32'hDEAD_BEEF}) begin
                    errors++;
                    $display("FAIL load_rsp vld=%b data=%h want 1 deadbeef", s0, q0);
                end
            end
            checks++;
            if ({s1, q1} !== 33'b0) begin
                errors++;
                $display("FAIL load_rsp1_quiet k=%0d vld=%b data=%h want 0", k, s1, q1);
            end
            next();
        end
    endtask

    task automatic test_store();
        do_reset();
        v1 = 1; a1 = 32'h20; w1 = 1; d1 = 32'h1234_5678; m1 = 4'b0011; v0 = 0;
        for (int k = 0; k <= LAT + 1; k++) begin
            if (k == 1) v1 = 0;
            model_cycle();
            #1;
            if (k == 0) begin
                checks++;
                if ({r0, r1} !== 2'b01) begin
                    errors++;
                    $display("FAIL store_rdy got %b%b want 01", r0, r1);
                end
            end
            if (k == 1) begin
                checks++;
                if ({en, mw, ma, md, mm} !== {1'b1, 1'b1, 32'h20, 32'h1234_5678, 4'b0011}) begin
                    errors++;
                    $display("FAIL store_issue en=%b wren=%b addr=%h wdata=%h bmask=%b want 1 1 00000020 12345678 0011",
                             en, mw, ma, md, mm);
                end
            end
            if (k == LAT + 1) begin
                checks++;
                if ({s1, q1} !== {1'b1, 32'h0}) begin
                    errors++;
                    $display("FAIL store_rsp vld=%b data=%h want 1 00000000", s1, q1);
                end
            end
            checks++;
            if (s0 !== 1'b0) begin
                errors++;
                $display("FAIL store_rsp0_quiet k=%0d vld=%b want 0", k, s0);
            end
            next();
        end
    endtask

    task automatic test_arbitration();
        int n;
        logic seq [4];
        logic want;
        do_reset();
        v0 = 1; a0 = 32'h100; w0 = 0; d0 = '0; m0 = '1;
        v1 = 1; a1 = 32'h200; w1 = 0; d1 = '0; m1 = '1;
        n = 0;
        for (int k = 0; k < 4 * (LAT + 2) + 4 && n < 4; k++) begin
            model_cycle();
            #1;
            checks++;
            if ({r0, r1} !== {e_r0, e_r1}) begin
                errors++;
                $display("FAIL arb_rdy cyc=%0d got %b%b want %b%b", cyc, r0, r1, e_r0, e_r1);
            end
            if (r0 || r1) begin
                seq[n] = r1;
                n++;
            end
            next();
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL arb_timeout handshakes=%0d want 4", n);
        end
        for (int i = 0; i < n; i++) begin
            want = RR ? 1'(i % 2) : 1'b0;
            checks++;
            if (seq[i] !== want) begin
                errors++;
                $display("FAIL arb_grant idx=%0d got port %0d want port %0d", i, seq[i], want);
            end
        end
        v0 = 0; v1 = 0;
        for (int k = 0; k < LAT + 2; k++) begin
            model_cycle();
            next();
        end
    endtask

    task automatic test_back_to_back();
        int hs_c [4];
        int rs_c [4];
        int nh, nr;
        do_reset();
        v0 = 1; w0 = 0; a0 = 32'h40; d0 = '0; m0 = '1; v1 = 0;
        nh = 0; nr = 0;
        for (int k = 0; k < 6 * (LAT + 2) && nr < 3; k++) begin
            if (e_r0) a0 = a0 + 32'h4;
            model_cycle();
            #1;
            if (r0 && nh < 4) begin
                hs_c[nh] = cyc;
                nh++;
            end
            if (s0 && nr < 4) begin
                rs_c[nr] = cyc;
                nr++;
                checks++;
                if (q0 !== e_d0) begin
                    errors++;
                    $display("FAIL b2b_rdata cyc=%0d got %h want %h", cyc, q0, e_d0);
                end
            end
            next();
        end
        v0 = 0;
        checks++;
        if (nr < 3 || nh < 3) begin
            errors++;
            $display("FAIL b2b_timeout rsps=%0d handshakes=%0d want 3", nr, nh);
        end else begin
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (hs_c[i] - hs_c[i-1] != LAT + 2) begin
                    errors++;
                    $display("FAIL b2b_spacing idx=%0d gap=%0d want %0d", i, hs_c[i] - hs_c[i-1], LAT + 2);
                end
            end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (rs_c[i] - hs_c[i] != LAT + 1) begin
                    errors++;
                    $display("FAIL b2b_latency idx=%0d lat=%0d want %0d", i, rs_c[i] - hs_c[i], LAT + 1);
                end
            end
        end
        for (int k = 0; k < LAT + 2; k++) begin
            model_cycle();
            next();
        end
    endtask

    task automatic test_late_vld();
        do_reset();
        v0 = 1; a0 = 32'h30; w0 = 0; d0 = '0; m0 = '1; v1 = 0;
        for (int k = 0; k <= LAT + 2; k++) begin
            if (k == 1) begin
                v0 = 0;
                v1 = 1; a1 = 32'h34; w1 = 1; d1 = 32'hCAFE_F00D; m1 = 4'b1100;
            end
            model_cycle();
            #1;
            if (k >= 1 && k <= LAT + 1) begin
                checks++;
                if (r1 !== 1'b0) begin
                    errors++;
                    $display("FAIL late_rdy_hold k=%0d rdy1=%b want 0", k, r1);
                end
            end
            if (k == LAT + 2) begin
                checks++;
                if (r1 !== 1'b1) begin
                    errors++;
                    $display("FAIL late_grant rdy1=%b want 1", r1);
                end
            end
            next();
        end
        v1 = 0;
        for (int k = 0; k < LAT + 2; k++) begin
            model_cycle();
            next();
        end
    endtask

    task automatic test_reset_wait();
        do_reset();
        v0 = 1; a0 = 32'h50; w0 = 0; d0 = '0; m0 = '1; v1 = 0;
        for (int k = 0; k < 2; k++) begin
            if (k == 1) v0 = 0;
            model_cycle();
            next();
        end
        rst = 1;
        v1 = 1; a1 = 32'h60; w1 = 1; d1 = 32'h0BAD_CAFE; m1 = 4'hF;
        #1;
        checks++;
        if ((r0 | r1 | s0 | s1 | en | busy | (|grant) | (|q0)) !== 1'b0) begin
            errors++;
            $display("FAIL rst_wait_outputs rdy=%b%b rsp=%b%b en=%b busy=%b grant=%b want 0",
                     r0, r1, s0, s1, en, busy, grant);
        end
        next();
        rst = 0;
        model_reset();
        for (int k = 0; k < LAT + 4; k++) begin
            if (k == 1) v1 = 0;
            model_cycle();
            #1;
            if (k == 0) begin
                checks++;
                if (r1 !== 1'b1) begin
                    errors++;
                    $display("FAIL rst_wait_first_hs rdy1=%b want 1", r1);
                end
            end
            checks++;
            if ({s0, s1} !== {e_s0, e_s1}) begin
                errors++;
                $display("FAIL rst_wait_rsp k=%0d got %b%b want %b%b", k, s0, s1, e_s0, e_s1);
            end
            next();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            if (!v0 || e_r0) begin
                v0 = ($urandom_range(0, 2) != 0);
                a0 = AW'($urandom_range(0, 7)) << 2;
                w0 = $urandom_range(0, 1) == 1;
                d0 = $urandom;
                m0 = BW'($urandom);
            end
            if (!v1 || e_r1) begin
                v1 = ($urandom_range(0, 2) != 0);
                a1 = AW'($urandom_range(0, 7)) << 2;
                w1 = $urandom_range(0, 1) == 1;
                d1 = $urandom;
                m1 = BW'($urandom);
            end
            model_cycle();
            #1;
            checks++;
            if ({r0, r1, en, mw, busy, grant, s0, s1} !==
                {e_r0, e_r1, e_en, e_wren, e_busy, e_grant, e_s0, e_s1}) begin
                errors++;
                $display("FAIL rnd_ctrl cyc=%0d rdy=%b%b en=%b wren=%b busy=%b grant=%b rsp=%b%b want %b%b %b %b %b %b %b%b",
                         cyc, r0, r1, en, mw, busy, grant, s0, s1,
                         e_r0, e_r1, e_en, e_wren, e_busy, e_grant, e_s0, e_s1);
            end
            checks++;
            if ({ma, md, mm} !== {e_addr, e_wdata, e_bmask}) begin
                errors++;
                $display("FAIL rnd_mem cyc=%0d addr=%h wdata=%h bmask=%b want %h %h %b",
                         cyc, ma, md, mm, e_addr, e_wdata, e_bmask);
            end
            checks++;
            if ({q0, q1} !== {e_d0, e_d1}) begin
                errors++;
                $display("FAIL rnd_rdata cyc=%0d rdata0=%h rdata1=%h want %h %h",
                         cyc, q0, q1, e_d0, e_d1);
            end
            next();
        end
        v0 = 0; v1 = 0;
    endtask

    initial begin
        rst = 1; v0 = 0; v1 = 0;
        a0 = '0; a1 = '0; w0 = 0; w1 = 0;
        d0 = '0; d1 = '0; m0 = '0; m1 = '0;
        mrd = '0;
        model_reset();
        test_reset();
        test_load();
        test_store();
        test_arbitration();
        test_back_to_back();
        test_late_vld();
        test_reset_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer that shares one synchronous data-memory port between two requesters: port 0 is the pipeline LSU, port 1 is the debug/program loader. It accepts one transaction at a time over a valid/ready handshake, drives the memory for one cycle, waits a fixed read latency and returns a single-cycle response pulse to the granted requester. It sits between the LSU/loader and the data memory inside the pipelined core.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte-mask width is DATA_W/8
- MEM_LAT, 1, memory read latency in cycles, legal 1..4
- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_reqN_vld  in  1  request valid, N in {0,1}
- o_reqN_rdy  out  1  request accepted this cycle
- i_reqN_addr  in  ADDR_W  byte address
- i_reqN_wren  in  1  1 = store, 0 = load
- i_reqN_wdata  in  DATA_W  store data
- i_reqN_bmask  in  DATA_W/8  store byte enables
- o_rspN_vld  out  1  response pulse, one cycle
- o_rspN_rdata  out  DATA_W  load data; 0 for stores
- o_mem_en  out  1  memory access strobe
- o_mem_wren  out  1  memory write enable
- o_mem_addr  out  ADDR_W  memory address
- o_mem_wdata  out  DATA_W  memory write data
- o_mem_bmask  out  DATA_W/8  memory byte enables
- i_mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after o_mem_en
- o_busy  out  1  high in ISSUE and WAIT
- o_grant  out  2  one-hot owner of current transaction, 0 when idle

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE: if any i_reqN_vld, select winner; o_reqN_rdy asserted combinationally for winner only, same cycle. On handshake capture addr/wren/wdata/bmask and owner; go to ISSUE.
- ISSUE: o_mem_en=1 with captured fields for exactly one cycle; o_mem_wren=captured wren; latency counter loaded with MEM_LAT-1; go to WAIT.
- WAIT: counter decrements each cycle; at 0, owner's o_rspN_vld=1, o_rspN_rdata=i_mem_rdata for loads or 0 for stores; go to IDLE the same cycle.
- Both rdy outputs are 0 outside IDLE; o_mem_* fields are 0 whenever o_mem_en=0.
- Requester rule: vld and payload stay stable until rdy; arbiter does not check this.
- Only the owner's rsp pulses; the other rsp port stays 0.
- Reset at any time: FSM to IDLE, any in-flight transaction dropped without response; all outputs 0, last-grant register = port 1.

## Timing
- Handshake at cycle T -> o_mem_en at T+1 -> o_rspN_vld at T+1+MEM_LAT (loads and stores identical).
- Next handshake earliest at T+2+MEM_LAT; throughput one transaction per MEM_LAT+2 cycles.
- o_grant and o_busy registered, change one cycle after handshake; o_grant clears on return to IDLE.
- Simultaneous vld on both ports in IDLE: resolved per Configuration; loser waits with vld held.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined: round robin; on conflict grant the port not granted last; last-grant register updates on each handshake, resets to port 1 so port 0 wins the first conflict.
- Undefined: fixed priority, port 0 always wins; last-grant register not built.

## Test plan
- MEM_LAT=1, port 0 load addr 0x0000_0010, memory returns 0xDEAD_BEEF -> rdy0 at T, o_mem_en/addr 0x10 at T+1, rsp0_vld with 0xDEAD_BEEF at T+2, rsp1 stays 0.
- Port 1 store addr 0x20 data 0x1234_5678 bmask 4'b0011 -> o_mem_wren=1, bmask 0011 at T+1; rsp1_vld with rdata 0 at T+1+MEM_LAT.
- Both ports hold vld for 4 transactions, round-robin build -> grants 0,1,0,1; fixed-priority build -> grants 0,0,0,0 and port 1 starved while port 0 valid.
- MEM_LAT=3, back-to-back port 0 loads -> handshakes 5 cycles apart, each rsp exactly 4 cycles after its handshake, rdy low in between.
- Assert i_rst during WAIT -> outputs 0 immediately, no rsp pulse; after release new request handshakes in first IDLE cycle.
- vld arrives on port 1 while port 0 in ISSUE -> rdy1 held 0 until IDLE, then granted.
